// File: rtl/cordic_shift_sequencer_if.sv
// rtl/cordic_shift_sequencer_if.sv - function control, operands/results and shared shifter/ROM signals
interface cordic_shift_sequencer_if;
  logic       start;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic [7:0] z_in;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [7:0] z_out;
  logic [7:0] sh_a;
  logic [2:0] sh_i;
  logic [7:0] sh_result;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;

  modport master (
    output start, x_in, y_in, z_in, sh_result, rom_data,
    input  busy, done, x_out, y_out, z_out, sh_a, sh_i, rom_addr
  );

  modport slave (
    input  start, x_in, y_in, z_in, sh_result, rom_data,
    output busy, done, x_out, y_out, z_out, sh_a, sh_i, rom_addr
  );
endinterface

// File: rtl/cordic_shift_sequencer.sv
// rtl/cordic_shift_sequencer.sv - rotation-mode CORDIC sequencer over one shared logical shifter
module cordic_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cordic_shift_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, SHIFT_X, SHIFT_Y, UPDATE, DONE} state_t;

  localparam logic [2:0] K_LAST = 3'(ITER - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [2:0]       k;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sh_a;
  logic             last_iter;

  assign last_iter = (k == K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    sh_a     = '0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = SHIFT_X;
      end
      SHIFT_X: begin
        busy     = 1'b1;
        // Inverting a negative operand around the logical shift yields floor division.
        sh_a     = x[WIDTH-1] ? ~x : x;
        state_nx = SHIFT_Y;
      end
      SHIFT_Y: begin
        busy     = 1'b1;
        sh_a     = y[WIDTH-1] ? ~y : y;
        state_nx = UPDATE;
      end
      UPDATE: begin
        busy     = 1'b1;
        state_nx = last_iter ? DONE : SHIFT_X;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x  <= '0;
      y  <= '0;
      z  <= '0;
      xs <= '0;
      ys <= '0;
      k  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x <= bus.x_in;
            y <= bus.y_in;
            z <= bus.z_in;
            k <= '0;
          end
        end
        SHIFT_X: xs <= x[WIDTH-1] ? ~bus.sh_result : bus.sh_result;
        SHIFT_Y: ys <= y[WIDTH-1] ? ~bus.sh_result : bus.sh_result;
        UPDATE: begin
          if (!z[WIDTH-1]) begin
            x <= x - ys;
            y <= y + xs;
            z <= z - bus.rom_data;
          end else begin
            x <= x + ys;
            y <= y - xs;
            z <= z + bus.rom_data;
          end
          if (!last_iter) k <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.sh_a     = sh_a;
  assign bus.sh_i     = k;
  assign bus.rom_addr = k;
  assign bus.x_out    = x;
  assign bus.y_out    = y;
  assign bus.z_out    = z;

endmodule

// File: tb/tb_cordic_shift_sequencer.sv
// tb/tb_cordic_shift_sequencer.sv - randomized bench for cordic_shift_sequencer against a behavioural CORDIC model
module tb_cordic_shift_sequencer;

  localparam int I8 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_shift_sequencer_if if8();
  cordic_shift_sequencer_if if1();

  cordic_shift_sequencer #(.WIDTH(8), .ITER(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  cordic_shift_sequencer #(.WIDTH(8), .ITER(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [7:0] atan_tab [8] = '{8'd32, 8'd19, 8'd10, 8'd5, 8'd3, 8'd1, 8'd1, 8'd0};

  assign if8.sh_result = if8.sh_a >> if8.sh_i;
  assign if8.rom_data  = atan_tab[if8.rom_addr];
  assign if1.sh_result = if1.sh_a >> if1.sh_i;
  assign if1.rom_data  = 8'd32;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ashr(input logic [7:0] v, input int s);
    logic signed [7:0] t;
    t = v;
    return t >>> s;
  endfunction

  function automatic logic [7:0] mag(input logic [7:0] v);
    return ($signed(v) < 0) ? 8'(-1 - $signed(v)) : v;
  endfunction

  // Behavioural model of the ITER=8 instance
  logic [7:0] gx [0:8];
  logic [7:0] gy [0:8];
  logic [7:0] gz [0:8];
  int         m_cyc   = 0;
  logic [2:0] m_k     = 3'd0;
  logic [7:0] m_fx    = 8'd0;
  logic [7:0] m_fy    = 8'd0;
  logic [7:0] m_fz    = 8'd0;
  int         exp_dones = 0;
  int         dones     = 0;

  task automatic golden(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] z0);
    logic [7:0] xs;
    logic [7:0] ys;
    gx[0] = x0;
    gy[0] = y0;
    gz[0] = z0;
    for (int k = 0; k < I8; k++) begin
      xs = ashr(gx[k], k);
      ys = ashr(gy[k], k);
      if ($signed(gz[k]) >= 0) begin
        gx[k+1] = gx[k] - ys;
        gy[k+1] = gy[k] + xs;
        gz[k+1] = gz[k] - atan_tab[k];
      end else begin
        gx[k+1] = gx[k] + ys;
        gy[k+1] = gy[k] - xs;
        gz[k+1] = gz[k] + atan_tab[k];
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0;
      m_k   = 3'd0;
      m_fx  = 8'd0;
      m_fy  = 8'd0;
      m_fz  = 8'd0;
    end else if (m_cyc == 0) begin
      if (if8.start === 1'b1) begin
        golden(if8.x_in, if8.y_in, if8.z_in);
        m_cyc = 1;
      end
    end else if (m_cyc == 3*I8 + 1) begin
      m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_cyc == 3*I8 + 1) begin
        m_k  = 3'(I8 - 1);
        m_fx = gx[I8];
        m_fy = gy[I8];
        m_fz = gz[I8];
        exp_dones++;
      end
    end
  end

  always @(negedge clk) begin
    int         k;
    int         ph;
    logic       eb;
    logic       ed;
    logic [2:0] ek;
    logic [7:0] esa;
    logic [7:0] ex;
    logic [7:0] ey;
    logic [7:0] ez;
    if (m_cyc == 0) begin
      eb = 1'b0; ed = 1'b0; ek = m_k; esa = 8'd0;
      ex = m_fx; ey = m_fy; ez = m_fz;
    end else if (m_cyc <= 3*I8) begin
      k  = (m_cyc - 1) / 3;
      ph = (m_cyc - 1) % 3;
      eb = 1'b1; ed = 1'b0; ek = 3'(k);
      esa = (ph == 0) ? mag(gx[k]) : (ph == 1) ? mag(gy[k]) : 8'd0;
      ex = gx[k]; ey = gy[k]; ez = gz[k];
    end else begin
      eb = 1'b0; ed = 1'b1; ek = 3'(I8 - 1); esa = 8'd0;
      ex = gx[I8]; ey = gy[I8]; ez = gz[I8];
    end
    check("busy8", if8.busy, eb);
    check("done8", if8.done, ed);
    check("sh_i8", if8.sh_i, ek);
    check("rom_addr8", if8.rom_addr, ek);
    check("sh_a8", if8.sh_a, esa);
    check("x_out8", if8.x_out, ex);
    check("y_out8", if8.y_out, ey);
    check("z_out8", if8.z_out, ez);
    if (if8.done === 1'b1) dones++;
  end

  task automatic run1(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                      input logic [7:0] esa, input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] ez);
    int n;
    @(posedge clk); #1;
    if1.start = 1'b1; if1.x_in = x; if1.y_in = y; if1.z_in = z;
    @(posedge clk); #1;
    if1.start = 1'b0; if1.x_in = ~x; if1.y_in = ~y; if1.z_in = ~z;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_sh_a"}, if1.sh_a, esa);
      if (n <= 3) check({tag, "_busy"}, if1.busy, 1'b1);
    end while (if1.done !== 1'b1 && n < 20);
    check({tag, "_latency"}, n, 4);
    check({tag, "_x"}, if1.x_out, ex);
    check({tag, "_y"}, if1.y_out, ey);
    check({tag, "_z"}, if1.z_out, ez);
    @(negedge clk);
    check({tag, "_done_pulse"}, if1.done, 1'b0);
    check({tag, "_x_hold"}, if1.x_out, ex);
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    int n;
    @(posedge clk); #1;
    if8.start = 1'b1; if8.x_in = x; if8.y_in = y; if8.z_in = z;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.x_in = 8'($urandom); if8.y_in = 8'($urandom); if8.z_in = 8'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (if8.done !== 1'b1 && n < 40);
    check("latency8", n, 25);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    if8.start = 1'b0; if8.x_in = 8'd0; if8.y_in = 8'd0; if8.z_in = 8'd0;
    if1.start = 1'b0; if1.x_in = 8'd0; if1.y_in = 8'd0; if1.z_in = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_busy1", if1.busy, 1'b0);
    check("rst_done1", if1.done, 1'b0);
    check("rst_x1", if1.x_out, 8'd0);
    check("rst_sh_a1", if1.sh_a, 8'd0);
    check("rst_sh_i1", if1.sh_i, 3'd0);

    check("pin_ashr_9c_k2", ashr(8'h9C, 2), 8'hE7);
    check("pin_ashr_ff_k7", ashr(8'hFF, 7), 8'hFF);
    check("pin_mag_9c", mag(8'h9C), 8'h63);
    golden(8'd64, 8'd0, 8'd10);
    check("pin_golden_x1", gx[1], 8'd64);
    check("pin_golden_y1", gy[1], 8'd64);
    check("pin_golden_z1", gz[1], 8'hEA);

    run1("t1", 8'd64, 8'd0, 8'd10, 8'd64, 8'd64, 8'd64, 8'hEA);
    run1("t6_wrap", 8'd127, 8'd127, 8'd0, 8'd127, 8'h00, 8'hFE, 8'hE0);
    run1("t2_neg", 8'h9C, 8'h00, 8'h00, 8'h63, 8'h9C, 8'h9C, 8'hE0);

    run8(8'h9C, 8'hFF, 8'h20);
    run8(8'h7F, 8'h80, 8'hC0);
    for (int i = 0; i < 20; i++) run8(8'($urandom), 8'($urandom), 8'($urandom));

    // Start held high with inputs scrambled every cycle
    for (int c = 0; c < 90; c++) begin
      @(posedge clk); #1;
      if8.start = 1'b1;
      if8.x_in = 8'($urandom); if8.y_in = 8'($urandom); if8.z_in = 8'($urandom);
    end
    if8.start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (m_cyc != 0 && n < 40);
    check("t4_drain", n < 40, 1'b1);

    // Reset during iteration k=3
    run8(8'($urandom), 8'($urandom), 8'($urandom));
    @(posedge clk); #1;
    if8.start = 1'b1; if8.x_in = 8'h55; if8.y_in = 8'h33; if8.z_in = 8'h11;
    n = 0;
    do begin
      @(posedge clk); #1;
      if8.start = 1'b0;
      n++;
    end while (m_cyc != 10 && n < 40);
    check("t5_reach_k3", if8.sh_i, 3'd3);
    rst_n = 1'b0;
    #1;
    check("t5_busy", if8.busy, 1'b0);
    check("t5_x", if8.x_out, 8'd0);
    check("t5_z", if8.z_out, 8'd0);
    check("t5_sh_i", if8.sh_i, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run8(8'h40, 8'h10, 8'hF0);
    run8(8'($urandom), 8'($urandom), 8'($urandom));

    repeat (3) @(negedge clk);
    check("done_count8", dones, exp_dones);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
